// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O unit on the data-memory bus. It provides debounced switch
// inputs with sticky change flags and an interrupt, seven-segment digits with a
// blank mask, and a free-running cycle counter. It decodes its own 256-byte
// window and returns registered read data one cycle after the load strobe.
module mmio_io_unit #(
  parameter int unsigned NUM_IN     = 2,
  parameter int unsigned IN_W       = 4,
  parameter int unsigned NUM_HEX    = 6,
  parameter int unsigned DEB_CYCLES = 16,
  parameter logic [31:0] BASE       = 32'h0000_0100
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic                      we,
  input  logic                      re,
  output logic                      hit,
  output logic [31:0]               rdata,
  output logic                      rvalid,
  input  logic [NUM_IN*IN_W-1:0]    sw_in,
  output logic [NUM_HEX*7-1:0]      hex_out,
  output logic                      irq
);

  // Word offsets of the control registers inside the window.
  localparam logic [5:0] OFF_CHG   = 6'h10;
  localparam logic [5:0] OFF_HEX   = 6'h11;
  localparam logic [5:0] OFF_BLANK = 6'h12;
  localparam logic [5:0] OFF_CNT   = 6'h13;
  localparam logic [5:0] OFF_IRQEN = 6'h14;

  // Debounce counter only has to reach DEB_CYCLES-1.
  localparam int unsigned DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [5:0] off;
  logic       rd_acc;
  logic       wr_acc;
  logic       wr_chg;
  logic       wr_hex;
  logic       wr_blank;
  logic       wr_cnt;
  logic       wr_irqen;

  logic [NUM_IN*IN_W-1:0] sync1_q;
  logic [NUM_IN*IN_W-1:0] sync2_q;
  logic [NUM_IN*IN_W-1:0] deb_q;
  logic [NUM_IN*IN_W-1:0] deb_d;
  logic [NUM_IN*DCW-1:0]  debcnt_q;
  logic [NUM_IN*DCW-1:0]  debcnt_d;
  logic [NUM_IN-1:0]      chg_set;

  logic [NUM_IN-1:0]      chg_q;
  logic [NUM_IN-1:0]      chg_d;
  logic [NUM_IN-1:0]      irqen_q;
  logic [NUM_IN-1:0]      irqen_d;
  logic [NUM_HEX*4-1:0]   hex_q;
  logic [NUM_HEX*4-1:0]   hex_d;
  logic [NUM_HEX-1:0]     blank_q;
  logic [NUM_HEX-1:0]     blank_d;
  logic [31:0]            cnt_q;
  logic [31:0]            cnt_d;
  logic                   irq_q;
  logic                   irq_d;

  logic [31:0]            rd_val;
  logic [31:0]            rdata_q;
  logic [31:0]            rdata_d;
  logic                   rvalid_q;

  // Byte-lane bits and store-data bits beyond the widest register are ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign hit    = (addr[31:8] == BASE[31:8]);
  assign off    = addr[7:2];
  assign rd_acc = re & hit;
  assign wr_acc = we & hit;

  assign wr_chg   = wr_acc && (off == OFF_CHG);
  assign wr_hex   = wr_acc && (off == OFF_HEX);
  assign wr_blank = wr_acc && (off == OFF_BLANK);
  assign wr_cnt   = wr_acc && (off == OFF_CNT);
  assign wr_irqen = wr_acc && (off == OFF_IRQEN);

  // Two-flop synchroniser for the raw asynchronous switch inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debouncer: accept a new value only after it has been stable long enough.
  always_comb begin
    deb_d    = deb_q;
    debcnt_d = '0;
    chg_set  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sync2_q[i*IN_W +: IN_W] != deb_q[i*IN_W +: IN_W]) begin
        if (debcnt_q[i*DCW +: DCW] == DEB_LAST) begin
          deb_d[i*IN_W +: IN_W] = sync2_q[i*IN_W +: IN_W];
          chg_set[i]            = 1'b1;
        end else begin
          debcnt_d[i*DCW +: DCW] = debcnt_q[i*DCW +: DCW] + DCW'(1);
        end
      end
    end
  end

  // Debounced values and their stability counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_q    <= '0;
      debcnt_q <= '0;
    end else begin
      deb_q    <= deb_d;
      debcnt_q <= debcnt_d;
    end
  end

  // Next state of the bus-visible registers; a fresh change flag beats a W1C clear.
  always_comb begin
    chg_d   = (chg_q & ~(wr_chg ? wdata[NUM_IN-1:0] : {NUM_IN{1'b0}})) | chg_set;
    irqen_d = wr_irqen ? wdata[NUM_IN-1:0] : irqen_q;
    hex_d   = wr_hex ? wdata[NUM_HEX*4-1:0] : hex_q;
    blank_d = wr_blank ? wdata[NUM_HEX-1:0] : blank_q;
    cnt_d   = wr_cnt ? 32'd0 : cnt_q + 32'd1;
    irq_d   = |(chg_q & irqen_q);
  end

  // Control register state; digits come up blanked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chg_q   <= '0;
      irqen_q <= '0;
      hex_q   <= '0;
      blank_q <= '1;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      chg_q   <= chg_d;
      irqen_q <= irqen_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (off == 6'(i)) begin
        rd_val = 32'(deb_q[i*IN_W +: IN_W]);
      end
    end
    case (off)
      OFF_CHG:   rd_val = 32'(chg_q);
      OFF_HEX:   rd_val = 32'(hex_q);
      OFF_BLANK: rd_val = 32'(blank_q);
      OFF_CNT:   rd_val = cnt_q;
      OFF_IRQEN: rd_val = 32'(irqen_q);
      default:   ;
    endcase
    rdata_d = rd_acc ? rd_val : rdata_q;
  end

  // Registered read data; rvalid pulses for the cycle after an accepted load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

  // Active-low seven-segment pattern, bit6=g down to bit0=a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  for (genvar d = 0; d < NUM_HEX; d++) begin : g_digit
    assign hex_out[d*7 +: 7] = blank_q[d] ? 7'h7F : seg7(hex_q[d*4 +: 4]);
  end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed self-checking bench for mmio_io_unit with default parameters.
module tb_mmio_io_unit;

  localparam logic [31:0] A_IN0   = 32'h0000_0100;
  localparam logic [31:0] A_IN1   = 32'h0000_0104;
  localparam logic [31:0] A_IN15  = 32'h0000_013C;
  localparam logic [31:0] A_CHG   = 32'h0000_0140;
  localparam logic [31:0] A_HEX   = 32'h0000_0144;
  localparam logic [31:0] A_BLANK = 32'h0000_0148;
  localparam logic [31:0] A_CNT   = 32'h0000_014C;
  localparam logic [31:0] A_IRQEN = 32'h0000_0150;
  localparam logic [31:0] A_NONE  = 32'h0000_0154;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  sw_in;
  logic [41:0] hex_out;
  logic        irq;

  int total = 0;
  int bad   = 0;

  mmio_io_unit #(
    .NUM_IN(2), .IN_W(4), .NUM_HEX(6), .DEB_CYCLES(16), .BASE(32'h0000_0100)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .hit(hit), .rdata(rdata), .rvalid(rvalid), .sw_in(sw_in), .hex_out(hex_out),
    .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sw);
    @(negedge clock);
    sw_in = sw;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    re    = 1'b0;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clock);
    addr = a;
    re   = 1'b1;
    we   = 1'b0;
    @(posedge clock);
    #1;
    re = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    checkOutput(tag, 64'(rdata), 64'(exp));
  endtask

  initial begin
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    re    = 1'b0;
    sw_in = '0;
    $display("[TB] start");

    // Reset state while reset is held.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_irq", 64'(irq), 64'd0);
    checkOutput("rst_hex", 64'(hex_out), 64'(ALL_BLANK));
    @(negedge clock);
    reset = 1'b0;

    // Every mapped register after reset.
    busRead(A_IN0, 32'h0, "rd_in0");
    @(posedge clock);
    #1;
    checkOutput("rvalid_one_cycle", 64'(rvalid), 64'd0);
    busRead(A_IN1, 32'h0, "rd_in1");
    busRead(A_CHG, 32'h0, "rd_chg0");
    busRead(A_HEX, 32'h0, "rd_hex0");
    busRead(A_BLANK, 32'h3F, "rd_blank0");
    busRead(A_IRQEN, 32'h0, "rd_irqen0");
    busRead(A_NONE, 32'h0, "rd_unmapped");
    busRead(A_IN15, 32'h0, "rd_in15");

    // Hex display decode and blanking.
    busWrite(A_HEX, 32'h0054_3210);
    busWrite(A_BLANK, 32'h0);
    checkOutput("hex_012345", 64'(hex_out),
                64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));
    busWrite(A_BLANK, 32'h2);
    checkOutput("hex_blank1", 64'(hex_out),
                64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h7F, 7'h40}));
    busWrite(A_BLANK, 32'h0);
    busWrite(A_HEX, 32'hFFDC_BA98);
    checkOutput("hex_89abcd", 64'(hex_out),
                64'({7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}));
    busRead(A_HEX, 32'h00DC_BA98, "rd_hex_trunc");
    busWrite(A_HEX, 32'h0000_FE76);
    checkOutput("hex_67ef", 64'(hex_out),
                64'({7'h40, 7'h40, 7'h0E, 7'h06, 7'h78, 7'h02}));

    // A short glitch on channel 0 is rejected.
    applyStimulus(8'h05);
    repeat (10) @(posedge clock);
    applyStimulus(8'h00);
    repeat (30) @(posedge clock);
    busRead(A_IN0, 32'h0, "glitch_in0");
    busRead(A_CHG, 32'h0, "glitch_chg");

    // Stable change on channel 0: visible after edge 18, not after edge 17.
    applyStimulus(8'h0A);
    repeat (17) @(posedge clock);
    busRead(A_IN0, 32'h0, "deb_edge17");
    busRead(A_IN0, 32'hA, "deb_edge18");
    busRead(A_CHG, 32'h1, "deb_chg");
    checkOutput("irq_masked", 64'(irq), 64'd0);

    // Enabling the interrupt raises irq one cycle later.
    busWrite(A_IRQEN, 32'h1);
    checkOutput("irq_en_same", 64'(irq), 64'd0);
    @(posedge clock);
    #1;
    checkOutput("irq_en_next", 64'(irq), 64'd1);

    // W1C on the same edge as a new channel 0 change: set wins.
    applyStimulus(8'h06);
    repeat (17) @(posedge clock);
    busWrite(A_CHG, 32'h1);
    @(posedge clock);
    #1;
    checkOutput("irq_setwins", 64'(irq), 64'd1);
    busRead(A_CHG, 32'h1, "chg_setwins");
    busRead(A_IN0, 32'h6, "in0_six");

    // W1C with nothing pending drops irq on the following cycle.
    busWrite(A_CHG, 32'h1);
    checkOutput("irq_w1c_same", 64'(irq), 64'd1);
    @(posedge clock);
    #1;
    checkOutput("irq_w1c_next", 64'(irq), 64'd0);
    busRead(A_CHG, 32'h0, "chg_cleared");

    // Channel 1 change is flagged but masked until enabled.
    applyStimulus(8'h36);
    repeat (20) @(posedge clock);
    busRead(A_IN1, 32'h3, "in1_three");
    busRead(A_CHG, 32'h2, "chg_ch1");
    checkOutput("irq_ch1_masked", 64'(irq), 64'd0);
    busWrite(A_IRQEN, 32'h3);
    @(posedge clock);
    #1;
    checkOutput("irq_ch1_en", 64'(irq), 64'd1);
    busRead(A_IRQEN, 32'h3, "rd_irqen3");
    busWrite(A_CHG, 32'h1);
    busRead(A_CHG, 32'h2, "chg_w1c_other");
    busWrite(A_CHG, 32'h2);
    @(posedge clock);
    #1;
    checkOutput("irq_ch1_clr", 64'(irq), 64'd0);

    // Writes to read-only inputs are ignored.
    busWrite(A_IN0, 32'hF);
    busRead(A_IN0, 32'h6, "ro_in0");

    // Cycle counter clears on write and counts from there.
    busWrite(A_CNT, 32'h1234);
    repeat (4) @(posedge clock);
    busRead(A_CNT, 32'h4, "cnt_after_write");

    // Load outside the window: no rvalid, rdata held.
    @(negedge clock);
    addr = 32'h0000_024C;
    re   = 1'b1;
    #1;
    checkOutput("hit_low", 64'(hit), 64'd0);
    @(posedge clock);
    #1;
    re = 1'b0;
    checkOutput("miss_rvalid", 64'(rvalid), 64'd0);
    checkOutput("miss_rdata", 64'(rdata), 64'd4);

    // Store and load together: write lands, read returns old value.
    @(negedge clock);
    addr  = A_HEX;
    wdata = 32'h0054_3210;
    we    = 1'b1;
    re    = 1'b1;
    #1;
    checkOutput("hit_high", 64'(hit), 64'd1);
    @(posedge clock);
    #1;
    we = 1'b0;
    re = 1'b0;
    checkOutput("rw_rvalid", 64'(rvalid), 64'd1);
    checkOutput("rw_rdata_old", 64'(rdata), 64'h0000_FE76);
    checkOutput("rw_hex_new", 64'(hex_out),
                64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));

    // Store outside the window is ignored.
    busWrite(32'h0000_0244, 32'h0);
    checkOutput("miss_write_hex", 64'(hex_out),
                64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));

    // Reset asserted right after a read completes clears everything at once.
    @(negedge clock);
    addr = A_HEX;
    re   = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("pre_rst_rvalid", 64'(rvalid), 64'd1);
    checkOutput("pre_rst_rdata", 64'(rdata), 64'h0054_3210);
    #2;
    reset = 1'b1;
    #1;
    re = 1'b0;
    checkOutput("mid_rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("mid_rst_rdata", 64'(rdata), 64'd0);
    checkOutput("mid_rst_hex", 64'(hex_out), 64'(ALL_BLANK));
    @(negedge clock);
    reset = 1'b0;
    busRead(A_BLANK, 32'h3F, "post_rst_blank");
    busRead(A_CHG, 32'h0, "post_rst_chg");

    // Inputs held through reset are re-debounced and flagged again.
    repeat (25) @(posedge clock);
    busRead(A_IN0, 32'h6, "post_rst_in0");
    busRead(A_IN1, 32'h3, "post_rst_in1");
    busRead(A_CHG, 32'h3, "post_rst_chg3");
    checkOutput("post_rst_irq", 64'(irq), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
